// File: rtl/mem_access.sv
// mem_access: memory stage between EX and write-back.
// ALU results pass straight to the output register. RV32I loads and stores are
// run one byte per cycle on an 8-bit RAM port, least significant byte first.
`timescale 1ns/1ps
module mem_access #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [6:0]            opcode_i,
  input  logic [2:0]            func3_i,
  input  logic [4:0]            wd_i,
  input  logic                  wreg_i,
  input  logic [31:0]           wdata_i,
  input  logic [31:0]           store_data_i,
  output logic [ADDR_WIDTH-1:0] mem_a_o,
  output logic [7:0]            mem_dout_o,
  output logic                  mem_wr_o,
  input  logic [7:0]            mem_din_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [4:0]            wd_o,
  output logic                  wreg_o,
  output logic [31:0]           wdata_o,
  output logic                  stall_req_o
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, STORE = 2'd2} state_t;

  state_t      state;
  state_t      state_nxt;
  logic        accept;
  logic        is_load;
  logic        is_store;
  logic [2:0]  idx;
  logic [2:0]  nxt_off;
  logic [1:0]  byte_sel;
  logic [31:0] addr_nxt;
  logic [7:0]  st_byte;
  logic [31:0] buf_nxt;

  // Transaction registers captured on accept (no reset: only read while busy)
  logic [31:0] addr_p1;
  logic [31:0] sdata_p1;
  logic [2:0]  func3_p1;
  logic [4:0]  wd_p1;
  logic        wreg_p1;
  logic [2:0]  nbytes_p1;
  logic [31:0] buf_p1;

  // Byte count of a load; unrecognised widths behave as LW.
  function automatic logic [2:0] load_len(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: load_len = 3'd1;
      3'b001, 3'b101: load_len = 3'd2;
      default:        load_len = 3'd4;
    endcase
  endfunction

  // Byte count of a store; unrecognised widths behave as SW.
  function automatic logic [2:0] store_len(input logic [2:0] f3);
    case (f3)
      3'b000:  store_len = 3'd1;
      3'b001:  store_len = 3'd2;
      default: store_len = 3'd4;
    endcase
  endfunction

  // Sign- or zero-extend the assembled load word according to its width.
  function automatic logic [31:0] load_extend(input logic [31:0] w, input logic [2:0] f3);
    logic signed [31:0] ext;
    case (f3)
      3'b000:  ext = signed'({{24{w[7]}}, w[7:0]});
      3'b001:  ext = signed'({{16{w[15]}}, w[15:0]});
      3'b100:  ext = signed'({24'd0, w[7:0]});
      3'b101:  ext = signed'({16'd0, w[15:0]});
      default: ext = signed'(w);
    endcase
    load_extend = ext;
  endfunction

  assign is_load  = (opcode_i == OP_LOAD);
  assign is_store = (opcode_i == OP_STORE);
  assign accept   = in_valid_i & in_ready_o;
  assign nxt_off  = idx + 3'd1;
  assign byte_sel = 2'(idx - 3'd1);
  assign addr_nxt = addr_p1 + {29'd0, nxt_off};
  assign st_byte  = sdata_p1[{nxt_off[1:0], 3'b000} +: 8];

  // Load word with the byte arriving this cycle merged in at its lane.
  always_comb begin
    buf_nxt = buf_p1;
    if ((state == LOAD) && (idx != 3'd0)) begin
      buf_nxt[{byte_sel, 3'b000} +: 8] = mem_din_i;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state: a load finishes once its last byte has returned, a store once its last byte is written.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept && is_load)       state_nxt = LOAD;
        else if (accept && is_store) state_nxt = STORE;
      end
      LOAD:    if (idx == nbytes_p1)     state_nxt = IDLE;
      STORE:   if (nxt_off == nbytes_p1) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs: accept only when idle and the output register is free or draining.
  always_comb begin
    in_ready_o  = (state == IDLE) & (~out_valid_o | out_ready_i);
    stall_req_o = in_valid_i & ~in_ready_o;
  end

  // Input capture stage (p0 -> p1): latch the transaction and collect load bytes.
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_p1   <= wdata_i;
      sdata_p1  <= store_data_i;
      func3_p1  <= func3_i;
      wd_p1     <= wd_i;
      wreg_p1   <= wreg_i;
      nbytes_p1 <= is_store ? store_len(func3_i) : load_len(func3_i);
    end
    if (state == LOAD) buf_p1 <= buf_nxt;
  end

  // RAM port and write-back register stage; reset abandons any access in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx         <= 3'd0;
      out_valid_o <= 1'b0;
      wd_o        <= 5'd0;
      wreg_o      <= 1'b0;
      wdata_o     <= 32'd0;
      mem_a_o     <= '0;
      mem_dout_o  <= 8'd0;
      mem_wr_o    <= 1'b0;
    end else begin
      if (out_valid_o && out_ready_i) out_valid_o <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            idx <= 3'd0;
            if (is_load) begin
              mem_a_o  <= wdata_i[ADDR_WIDTH-1:0];
              mem_wr_o <= 1'b0;
            end else if (is_store) begin
              mem_a_o    <= wdata_i[ADDR_WIDTH-1:0];
              mem_dout_o <= store_data_i[7:0];
              mem_wr_o   <= 1'b1;
            end else begin
              out_valid_o <= 1'b1;
              wd_o        <= wd_i;
              wreg_o      <= wreg_i & (wd_i != 5'd0);
              wdata_o     <= wdata_i;
            end
          end
        end
        LOAD: begin
          idx <= nxt_off;
          if (idx == nbytes_p1) begin
            out_valid_o <= 1'b1;
            wd_o        <= wd_p1;
            wreg_o      <= wreg_p1 & (wd_p1 != 5'd0);
            wdata_o     <= load_extend(buf_nxt, func3_p1);
          end else if (nxt_off < nbytes_p1) begin
            mem_a_o <= addr_nxt[ADDR_WIDTH-1:0];
          end
        end
        STORE: begin
          idx <= nxt_off;
          if (nxt_off == nbytes_p1) begin
            mem_wr_o    <= 1'b0;
            out_valid_o <= 1'b1;
            wd_o        <= wd_p1;
            wreg_o      <= 1'b0;
            wdata_o     <= addr_p1;
          end else begin
            mem_a_o    <= addr_nxt[ADDR_WIDTH-1:0];
            mem_dout_o <= st_byte;
          end
        end
        default: mem_wr_o <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: table of EX transactions plus hand-written backpressure,
// busy-input and mid-store reset sequences, checked through a scoreboard.
`timescale 1ns/1ps
module tb_mem_access;

  localparam int AW = 32;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_ALU = 7'b0110011;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid_i;
  logic          in_ready_o;
  logic [6:0]    opcode_i;
  logic [2:0]    func3_i;
  logic [4:0]    wd_i;
  logic          wreg_i;
  logic [31:0]   wdata_i;
  logic [31:0]   store_data_i;
  logic [AW-1:0] mem_a_o;
  logic [7:0]    mem_dout_o;
  logic          mem_wr_o;
  logic [7:0]    mem_din_i;
  logic          out_valid_o;
  logic          out_ready_i;
  logic [4:0]    wd_o;
  logic          wreg_o;
  logic [31:0]   wdata_o;
  logic          stall_req_o;

  mem_access #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .opcode_i(opcode_i), .func3_i(func3_i), .wd_i(wd_i), .wreg_i(wreg_i),
    .wdata_i(wdata_i), .store_data_i(store_data_i), .mem_a_o(mem_a_o),
    .mem_dout_o(mem_dout_o), .mem_wr_o(mem_wr_o), .mem_din_i(mem_din_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .wd_o(wd_o),
    .wreg_o(wreg_o), .wdata_o(wdata_o), .stall_req_o(stall_req_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] op; logic [2:0] f3; logic [4:0] wd; logic wreg;
    logic [31:0] a; logic [31:0] sd;
    logic [4:0] ewd; logic ewreg; logic [31:0] edata;
  } vec_t;
  typedef struct { int id; int due; logic [4:0] wd; logic wreg; logic [31:0] wdata; } exp_t;
  typedef struct { int cyc; logic [31:0] addr; } rd_t;
  typedef struct { int cyc; logic [31:0] addr; logic [7:0] data; } wr_t;

  exp_t expq[$];
  rd_t  rdq[$];
  wr_t  wrq[$];
  vec_t tbl[19];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [7:0] ram [0:1023];

  always @(posedge clk) cyc <= cyc + 1;

  // Byte-wide RAM: read data one cycle after the address, writes on the strobe.
  always @(posedge clk) begin
    mem_din_i <= ram[mem_a_o[9:0]];
    if (mem_wr_o) ram[mem_a_o[9:0]] <= mem_dout_o;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  function automatic int nbytes(input logic st, input logic [2:0] f3);
    if (st) return (f3 == 3'b000) ? 1 : (f3 == 3'b001) ? 2 : 4;
    if (f3 == 3'b000 || f3 == 3'b100) return 1;
    if (f3 == 3'b001 || f3 == 3'b101) return 2;
    return 4;
  endfunction

  // Scoreboard monitor: RAM addresses, RAM writes and write-back results.
  logic seen = 1'b0;
  int   vcyc = 0;
  always @(negedge clk) begin
    rd_t  r;
    wr_t  w;
    exp_t e;
    if (!rst) begin
      seen = 1'b0;
    end else begin
      if (rdq.size() > 0 && rdq[0].cyc == cyc) begin
        r = rdq.pop_front();
        chk("rd_addr", mem_a_o, r.addr);
        chk("rd_no_write", {31'd0, mem_wr_o}, 32'd0);
      end
      if (mem_wr_o) begin
        if (wrq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_write: addr 0x%08h data 0x%02h at cycle %0d", mem_a_o, mem_dout_o, cyc);
        end else begin
          w = wrq.pop_front();
          chk("wr_cycle", cyc, w.cyc);
          chk("wr_addr", mem_a_o, w.addr);
          chk("wr_data", {24'd0, mem_dout_o}, {24'd0, w.data});
        end
      end
      if (out_valid_o) begin
        if (!seen) begin seen = 1'b1; vcyc = cyc; end
        if (out_ready_i) begin
          seen = 1'b0;
          if (expq.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_result: wd %0d wdata 0x%08h", wd_o, wdata_o);
          end else begin
            e = expq.pop_front();
            chk($sformatf("id%0d_cycle", e.id), vcyc, e.due);
            chk($sformatf("id%0d_wd", e.id), {27'd0, wd_o}, {27'd0, e.wd});
            chk($sformatf("id%0d_wreg", e.id), {31'd0, wreg_o}, {31'd0, e.wreg});
            chk($sformatf("id%0d_wdata", e.id), wdata_o, e.wdata);
          end
        end
      end
    end
  end

  task automatic issue(input int id, input vec_t v);
    int n; int g; int c1; logic ld; logic st; exp_t e;
    ld = (v.op == OP_LD);
    st = (v.op == OP_ST);
    n  = nbytes(st, v.f3);
    @(negedge clk);
    opcode_i = v.op; func3_i = v.f3; wd_i = v.wd; wreg_i = v.wreg;
    wdata_i = v.a; store_data_i = v.sd; in_valid_i = 1'b1;
    g = 0;
    while (!in_ready_o && g < 200) begin @(negedge clk); g++; end
    if (!in_ready_o) begin
      checks++; errors++;
      $display("FAIL id%0d_accept_timeout: in_ready_o stayed 0", id);
      in_valid_i = 1'b0;
      return;
    end
    @(posedge clk); #1;
    in_valid_i = 1'b0;
    c1 = cyc;
    e.id = id; e.wd = v.ewd; e.wreg = v.ewreg; e.wdata = v.edata;
    e.due = ld ? c1 + n + 1 : st ? c1 + n : c1;
    expq.push_back(e);
    for (int k = 0; k < n; k++) begin
      if (ld) rdq.push_back('{c1 + k, v.a + 32'(k)});
      if (st) wrq.push_back('{c1 + k, v.a + 32'(k), v.sd[8*k +: 8]});
    end
  endtask

  task automatic drain();
    int g = 0;
    while ((expq.size() != 0 || rdq.size() != 0 || wrq.size() != 0) && g < 100) begin
      @(negedge clk); g++;
    end
    if (g >= 100) begin
      checks++; errors++;
      $display("FAIL drain_timeout: %0d results, %0d reads, %0d writes outstanding",
               expq.size(), rdq.size(), wrq.size());
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    rst = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b1;
    opcode_i = '0; func3_i = '0; wd_i = '0; wreg_i = 1'b0; wdata_i = '0; store_data_i = '0;
    for (int i = 0; i < 1024; i++) ram[i] = 8'h00;
    ram[10'h100] = 8'h78; ram[10'h101] = 8'h56; ram[10'h102] = 8'h34; ram[10'h103] = 8'h12;
    ram[10'h200] = 8'h80; ram[10'h201] = 8'hFF;
    ram[10'h3FF] = 8'h11; ram[10'h000] = 8'h22; ram[10'h001] = 8'h33; ram[10'h002] = 8'h44;
    ram[10'h301] = 8'hA1; ram[10'h302] = 8'hB2; ram[10'h303] = 8'hC3; ram[10'h304] = 8'hD4;

    tbl[0]  = '{OP_ALU, 3'b000, 5'd5,  1'b1, 32'h0000_1234, 32'h0, 5'd5,  1'b1, 32'h0000_1234};
    tbl[1]  = '{OP_ALU, 3'b000, 5'd0,  1'b1, 32'h0000_DEAD, 32'h0, 5'd0,  1'b0, 32'h0000_DEAD};
    tbl[2]  = '{OP_ALU, 3'b000, 5'd7,  1'b0, 32'h0000_0055, 32'h0, 5'd7,  1'b0, 32'h0000_0055};
    tbl[3]  = '{OP_LD,  3'b010, 5'd3,  1'b1, 32'h0000_0100, 32'h0, 5'd3,  1'b1, 32'h1234_5678};
    tbl[4]  = '{OP_LD,  3'b000, 5'd4,  1'b1, 32'h0000_0200, 32'h0, 5'd4,  1'b1, 32'hFFFF_FF80};
    tbl[5]  = '{OP_LD,  3'b100, 5'd4,  1'b1, 32'h0000_0200, 32'h0, 5'd4,  1'b1, 32'h0000_0080};
    tbl[6]  = '{OP_LD,  3'b001, 5'd6,  1'b1, 32'h0000_0200, 32'h0, 5'd6,  1'b1, 32'hFFFF_FF80};
    tbl[7]  = '{OP_LD,  3'b101, 5'd6,  1'b1, 32'h0000_0200, 32'h0, 5'd6,  1'b1, 32'h0000_FF80};
    tbl[8]  = '{OP_LD,  3'b010, 5'd8,  1'b1, 32'hFFFF_FFFF, 32'h0, 5'd8,  1'b1, 32'h4433_2211};
    tbl[9]  = '{OP_LD,  3'b010, 5'd9,  1'b1, 32'h0000_0301, 32'h0, 5'd9,  1'b1, 32'hD4C3_B2A1};
    tbl[10] = '{OP_LD,  3'b011, 5'd10, 1'b1, 32'h0000_0100, 32'h0, 5'd10, 1'b1, 32'h1234_5678};
    tbl[11] = '{OP_ST,  3'b001, 5'd9,  1'b1, 32'h0000_0003, 32'hAABB_CCDD, 5'd9, 1'b0, 32'h0000_0003};
    tbl[12] = '{OP_ST,  3'b000, 5'd1,  1'b1, 32'h0000_0050, 32'h0000_00EE, 5'd1, 1'b0, 32'h0000_0050};
    tbl[13] = '{OP_ST,  3'b010, 5'd2,  1'b1, 32'h0000_0060, 32'h0102_0304, 5'd2, 1'b0, 32'h0000_0060};
    tbl[14] = '{OP_ST,  3'b100, 5'd3,  1'b1, 32'h0000_0070, 32'h0A0B_0C0D, 5'd3, 1'b0, 32'h0000_0070};
    tbl[15] = '{OP_LD,  3'b010, 5'd11, 1'b1, 32'h0000_0060, 32'h0, 5'd11, 1'b1, 32'h0102_0304};
    tbl[16] = '{OP_LD,  3'b100, 5'd12, 1'b1, 32'h0000_0050, 32'h0, 5'd12, 1'b1, 32'h0000_00EE};
    tbl[17] = '{OP_LD,  3'b010, 5'd13, 1'b1, 32'h0000_0070, 32'h0, 5'd13, 1'b1, 32'h0A0B_0C0D};
    tbl[18] = '{OP_LD,  3'b000, 5'd0,  1'b1, 32'h0000_0050, 32'h0, 5'd0,  1'b0, 32'hFFFF_FFEE};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid_o}, 32'd0);
    chk("rst_wd", {27'd0, wd_o}, 32'd0);
    chk("rst_wreg", {31'd0, wreg_o}, 32'd0);
    chk("rst_wdata", wdata_o, 32'd0);
    chk("rst_mem_a", mem_a_o, 32'd0);
    chk("rst_mem_dout", {24'd0, mem_dout_o}, 32'd0);
    chk("rst_mem_wr", {31'd0, mem_wr_o}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("idle_in_ready", {31'd0, in_ready_o}, 32'd1);

    // Vector table, issued back to back
    for (int i = 0; i < 19; i++) issue(i, tbl[i]);
    drain();

    // Write-back stall: result held, input refused while blocked
    @(posedge clk); #1;
    out_ready_i = 1'b0;
    v = '{OP_ALU, 3'b000, 5'd11, 1'b1, 32'h0000_CAFE, 32'h0, 5'd11, 1'b1, 32'h0000_CAFE};
    issue(100, v);
    opcode_i = OP_ALU; wd_i = 5'd12; wreg_i = 1'b1; wdata_i = 32'h0000_BEEF; in_valid_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_out_valid", {31'd0, out_valid_o}, 32'd1);
      chk("bp_wd", {27'd0, wd_o}, 32'd11);
      chk("bp_wdata", wdata_o, 32'h0000_CAFE);
      chk("bp_in_ready", {31'd0, in_ready_o}, 32'd0);
      chk("bp_stall", {31'd0, stall_req_o}, 32'd1);
    end
    @(posedge clk); #1;
    out_ready_i = 1'b1;
    v = '{OP_ALU, 3'b000, 5'd12, 1'b1, 32'h0000_BEEF, 32'h0, 5'd12, 1'b1, 32'h0000_BEEF};
    issue(101, v);
    drain();

    // Input offered during a load is ignored and stalls
    v = '{OP_LD, 3'b010, 5'd14, 1'b1, 32'h0000_0100, 32'h0, 5'd14, 1'b1, 32'h1234_5678};
    issue(102, v);
    opcode_i = OP_ALU; wd_i = 5'd20; wreg_i = 1'b1; wdata_i = 32'h0000_0999; in_valid_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("busy_stall", {31'd0, stall_req_o}, 32'd1);
      chk("busy_in_ready", {31'd0, in_ready_o}, 32'd0);
    end
    in_valid_i = 1'b0;
    drain();

    // Reset in the second cycle of a word store
    v = '{OP_ST, 3'b010, 5'd15, 1'b1, 32'h0000_0080, 32'h5566_7788, 5'd15, 1'b0, 32'h0000_0080};
    issue(103, v);
    @(posedge clk); #1;
    rst = 1'b0;
    expq.delete(); rdq.delete(); wrq.delete();
    #1;
    chk("mid_rst_mem_wr", {31'd0, mem_wr_o}, 32'd0);
    chk("mid_rst_mem_a", mem_a_o, 32'd0);
    chk("mid_rst_mem_dout", {24'd0, mem_dout_o}, 32'd0);
    chk("mid_rst_out_valid", {31'd0, out_valid_o}, 32'd0);
    chk("mid_rst_wdata", wdata_o, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    chk("mid_rst_byte0", {24'd0, ram[10'h080]}, 32'h88);
    chk("mid_rst_byte1", {24'd0, ram[10'h081]}, 32'h00);
    v = '{OP_LD, 3'b010, 5'd16, 1'b1, 32'h0000_0100, 32'h0, 5'd16, 1'b1, 32'h1234_5678};
    issue(104, v);
    v = '{OP_LD, 3'b010, 5'd17, 1'b1, 32'h0000_0080, 32'h0, 5'd17, 1'b1, 32'h0000_0088};
    issue(105, v);
    drain();

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
